text_buffer_ram: RTL and testbench

- Parametrised simple-dual-port, single-clock text buffer RAM; successor to the fixed 39-bit character store.
- Adds a selectable read latency with a matching valid pipeline, a write-ready handshake, and a hardware clear sequencer that sweeps every entry to a fill value.
- Sits between the text writer (write port) and the character renderer (read port).

---
 rtl/text_buffer_ram.sv | 172 +++++++++++++++++
 tb/tb_text_buffer_ram.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_buffer_ram.sv
// rtl/text_buffer_ram.sv - simple-dual-port text buffer RAM with read pipeline and clear sequencer (option macro: TEXT_BUFFER_RAM_BYPASS_EN)
module text_buffer_ram #(
  parameter int               WIDTH       = 39,
  parameter int               DEPTH       = 64,
  parameter int               AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int               LATENCY     = 2,
  parameter logic [WIDTH-1:0] CLEAR_VALUE = {WIDTH{1'b0}},
  parameter string            INIT_FILE   = ""
) (
  input  logic             clka,
  input  logic             rsta_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ready,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  input  logic             clr_req,
  output logic             clr_busy,
  output logic             clr_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // One extra bit so the range check stays meaningful when DEPTH is a power of two.
  localparam logic [AW:0]   DEPTH_LIM = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];

  state_t           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;

  logic             wr_in_range;
  logic             rd_in_range;
  logic             ext_we;
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] rd_word;
  logic [WIDTH-1:0] rd_data_s1;
  logic             rd_valid_s1;

  // Power-up contents: all zero.
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = '0;
    end
  end

  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_LIM);
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_LIM);
  assign ext_we      = wr_en && wr_ready && wr_in_range;

  // Clear sequencer state and sweep counter; reset aborts a sweep without a done pulse.
  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Clear sequencer next state and status outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clr_busy = 1'b0;
    clr_done = 1'b0;
    wr_ready = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (clr_req) begin
          state_d = S_SWEEP;
          cnt_d   = '0;
        end
      end
      S_SWEEP: begin
        clr_busy = 1'b1;
        wr_ready = 1'b0;
        if (cnt_q == LAST_ADDR) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        clr_done = 1'b1;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Single write port shared by the sweep and the external writer (never both at once).
  always_comb begin
    mem_we    = ext_we;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    if (state_q == S_SWEEP) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q;
      mem_wdata = CLEAR_VALUE;
    end
  end

  // Array write; the storage itself is never reset.
  always @(posedge clka) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Word presented to the first read stage; out-of-range reads yield zero.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = mem[rd_addr];
`ifdef TEXT_BUFFER_RAM_BYPASS_EN
      if (mem_we && (mem_waddr == rd_addr)) begin
        rd_word = mem_wdata;
      end
`endif
    end
  end

  // First read stage: captures on request, holds otherwise.
  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      rd_data_s1  <= '0;
      rd_valid_s1 <= 1'b0;
    end else begin
      rd_valid_s1 <= rd_en;
      if (rd_en) begin
        rd_data_s1 <= rd_word;
      end
    end
  end

  generate
    if (LATENCY == 2) begin : g_lat2
      // Output register: advances only when a read completes so rd_data holds between reads.
      always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
          rd_data  <= '0;
          rd_valid <= 1'b0;
        end else begin
          rd_valid <= rd_valid_s1;
          if (rd_valid_s1) begin
            rd_data <= rd_data_s1;
          end
        end
      end
    end else begin : g_lat1
      assign rd_data  = rd_data_s1;
      assign rd_valid = rd_valid_s1;
    end
  endgenerate

endmodule

// File: tb/tb_text_buffer_ram.sv
// tb/tb_text_buffer_ram.sv - randomized self-checking bench for text_buffer_ram against a behavioural model
module tb_text_buffer_ram;

  localparam int               W   = 39;
  localparam int               D   = 64;
  localparam int               L   = 2;
  localparam logic [W-1:0]     CLR = 39'h20;
  localparam int               D2  = 40;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;

  logic         wr_en   = 1'b0;
  logic [5:0]   wr_addr = '0;
  logic [W-1:0] wr_data = '0;
  logic         wr_ready;
  logic         rd_en   = 1'b0;
  logic [5:0]   rd_addr = '0;
  logic [W-1:0] rd_data;
  logic         rd_valid;
  logic         clr_req = 1'b0;
  logic         clr_busy;
  logic         clr_done;

  logic         a_wr_en   = 1'b0;
  logic [5:0]   a_wr_addr = '0;
  logic [W-1:0] a_wr_data = '0;
  logic         a_wr_ready;
  logic         a_rd_en   = 1'b0;
  logic [5:0]   a_rd_addr = '0;
  logic [W-1:0] a_rd_data;
  logic         a_rd_valid;
  logic         a_clr_req = 1'b0;
  logic         a_clr_busy;
  logic         a_clr_done;

  always #5 clk = ~clk;

  text_buffer_ram #(.WIDTH(W), .DEPTH(D), .LATENCY(L), .CLEAR_VALUE(CLR)) u_dut (
    .clka(clk), .rsta_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
  );

  text_buffer_ram #(.WIDTH(W), .DEPTH(D2), .LATENCY(1)) u_alt (
    .clka(clk), .rsta_n(rst_n),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data), .wr_ready(a_wr_ready),
    .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_valid(a_rd_valid),
    .clr_req(a_clr_req), .clr_busy(a_clr_busy), .clr_done(a_clr_done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Behavioural reference: memory contents, sweep position (-1 = none), done flag, read history.
  logic [W-1:0] m_mem [D];
  int           sweep_idx = -1;
  bit           m_done    = 1'b0;
  bit           pv [$];
  logic [W-1:0] pd [$];
  bit           e_valid   = 1'b0;
  logic [W-1:0] e_data    = '0;

  task automatic model_reset();
    sweep_idx = -1;
    m_done    = 1'b0;
    pv.delete();
    pd.delete();
    e_valid   = 1'b0;
    e_data    = '0;
  endtask

  task automatic model_edge();
    bit           sweeping;
    bit           wacc;
    int           waddr;
    logic [W-1:0] wdat;
    logic [W-1:0] rv;
    sweeping = (sweep_idx >= 0);
    wacc  = 1'b0;
    waddr = 0;
    wdat  = '0;
    if (sweeping) begin
      wacc = 1'b1; waddr = sweep_idx; wdat = CLR;
    end else if (wr_en && int'(wr_addr) < D) begin
      wacc = 1'b1; waddr = int'(wr_addr); wdat = wr_data;
    end
    rv = '0;
    if (rd_en && int'(rd_addr) < D) begin
      rv = m_mem[rd_addr];
`ifdef TEXT_BUFFER_RAM_BYPASS_EN
      if (wacc && waddr == int'(rd_addr)) rv = wdat;
`endif
    end
    if (wacc) m_mem[waddr] = wdat;
    if (sweeping) begin
      if (sweep_idx == D - 1) begin
        sweep_idx = -1;
        m_done    = 1'b1;
      end else begin
        sweep_idx++;
      end
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (clr_req) begin
      sweep_idx = 0;
    end
    pv.push_back(rd_en);
    pd.push_back(rv);
    while (pv.size() > L) begin
      void'(pv.pop_front());
      void'(pd.pop_front());
    end
    if (pv.size() == L) begin
      e_valid = pv[0];
      if (pv[0]) e_data = pd[0];
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("rd_valid", rd_valid, e_valid);
    check("rd_data", rd_data, e_data);
    check("clr_busy", clr_busy, sweep_idx >= 0);
    check("clr_done", clr_done, m_done);
    check("wr_ready", wr_ready, !(sweep_idx >= 0));
  endtask

  task automatic rd_check(input int a, input logic [W-1:0] exp, input string tag);
    rd_en = 1'b1; rd_addr = 6'(a);
    step();
    rd_en = 1'b0;
    repeat (L - 1) step();
    check({tag, "_valid"}, rd_valid, 1);
    check(tag, rd_data, exp);
  endtask

  task automatic fill(input logic [W-1:0] v);
    for (int i = 0; i < D; i++) begin
      wr_en = 1'b1; wr_addr = 6'(i); wr_data = v;
      step();
    end
    wr_en = 1'b0;
  endtask

  initial begin
    int nbusy, nnr, ndone, guard;
    logic [W-1:0] same_exp;

    for (int i = 0; i < D; i++) m_mem[i] = '0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_clr_busy", clr_busy, 0);
    check("rst_clr_done", clr_done, 0);
    check("rst_wr_ready", wr_ready, 1);
    rst_n = 1'b1;

    // Read of address 5 after reset: valid exactly two cycles later
    rd_en = 1'b1; rd_addr = 6'd5;
    step();
    rd_en = 1'b0;
    check("rd5_c1_valid", rd_valid, 0);
    step();
    check("rd5_c2_valid", rd_valid, 1);
    check("rd5_c2_data", rd_data, 0);
    step();
    check("rd5_c3_valid", rd_valid, 0);

    // Write then read at latency 2
    wr_en = 1'b1; wr_addr = 6'd10; wr_data = 39'h12_3456_789A;
    step();
    wr_en = 1'b0;
    rd_en = 1'b1; rd_addr = 6'd10;
    step();
    rd_en = 1'b0;
    step();
    check("wr_rd10_data", rd_data, 39'h12_3456_789A);
    check("wr_rd10_valid", rd_valid, 1);

    // Same-cycle write and read of address 3
    wr_en = 1'b1; wr_addr = 6'd3; wr_data = 39'h7;
    step();
    wr_data = 39'h1; rd_en = 1'b1; rd_addr = 6'd3;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    step();
`ifdef TEXT_BUFFER_RAM_BYPASS_EN
    same_exp = 39'h1;
`else
    same_exp = 39'h7;
`endif
    check("same_cycle_rw", rd_data, same_exp);

    // Random traffic with occasional clear requests
    for (int i = 0; i < 400; i++) begin
      wr_en   = 1'($urandom_range(0, 1));
      wr_addr = 6'($urandom_range(0, D - 1));
      wr_data = W'({$urandom(), $urandom()});
      rd_en   = 1'($urandom_range(0, 1));
      rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 6'($urandom_range(0, D - 1));
      clr_req = ($urandom_range(0, 149) == 0);
      step();
    end
    wr_en = 1'b0; rd_en = 1'b0; clr_req = 1'b0;
    repeat (D + 4) step();

    // Full sweep over a filled buffer, with a write attempted mid-sweep
    fill(39'h55);
    nbusy = 0; nnr = 0; ndone = 0;
    for (int i = 0; i < D + 8; i++) begin
      clr_req = (i == 0);
      wr_en   = (i == 20);
      wr_addr = 6'd7;
      wr_data = 39'h99;
      step();
      if (clr_busy) nbusy++;
      if (!wr_ready) nnr++;
      if (clr_done) ndone++;
    end
    clr_req = 1'b0; wr_en = 1'b0;
    check("sweep_busy_cycles", nbusy, D);
    check("sweep_not_ready_cycles", nnr, D);
    check("sweep_done_pulses", ndone, 1);
    for (int a = 0; a < D; a++) begin
      rd_en = 1'b1; rd_addr = 6'(a);
      step();
    end
    rd_en = 1'b0;
    repeat (L) step();
    rd_check(7, CLR, "mid_sweep_wr_dropped");
    rd_check(63, CLR, "sweep_last_addr");

    // Reset at sweep cycle 30
    fill(39'h55);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    guard = 0;
    while (sweep_idx != 30 && guard < 100) begin
      step();
      guard++;
    end
    check("sweep_reach_30", guard < 100, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", clr_busy, 0);
    check("abort_done", clr_done, 0);
    check("abort_wr_ready", wr_ready, 1);
    check("abort_rd_valid", rd_valid, 0);
    model_reset();
    #2;
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < D; i++) begin
      step();
      if (clr_done) ndone++;
    end
    check("abort_no_done", ndone, 0);
    rd_check(0, CLR, "abort_addr0");
    rd_check(29, CLR, "abort_addr29");
    rd_check(30, 39'h55, "abort_addr30");
    rd_check(63, 39'h55, "abort_addr63");
    for (int a = 0; a < D; a++) begin
      rd_en = 1'b1; rd_addr = 6'(a);
      step();
    end
    rd_en = 1'b0;
    repeat (L) step();

    // DEPTH=40, LATENCY=1 instance
    a_wr_en = 1'b1; a_wr_addr = 6'd10; a_wr_data = 39'h12_3456_789A;
    step();
    a_wr_en = 1'b0;
    a_rd_en = 1'b1; a_rd_addr = 6'd10;
    step();
    a_rd_en = 1'b0;
    check("alt_lat1_valid", a_rd_valid, 1);
    check("alt_lat1_data", a_rd_data, 39'h12_3456_789A);
    step();
    check("alt_valid_pulse", a_rd_valid, 0);
    check("alt_data_hold", a_rd_data, 39'h12_3456_789A);
    a_wr_en = 1'b1; a_wr_addr = 6'd45; a_wr_data = 39'h3FF;
    step();
    a_wr_en = 1'b0;
    a_rd_en = 1'b1; a_rd_addr = 6'd45;
    step();
    check("alt_oob_valid", a_rd_valid, 1);
    check("alt_oob_data", a_rd_data, 0);
    a_rd_addr = 6'd5;
    step();
    a_rd_en = 1'b0;
    check("alt_no_alias", a_rd_data, 0);
    nbusy = 0; ndone = 0;
    for (int i = 0; i < D2 + 8; i++) begin
      a_clr_req = (i == 0);
      step();
      if (a_clr_busy) nbusy++;
      if (a_clr_done) ndone++;
    end
    a_clr_req = 1'b0;
    check("alt_sweep_cycles", nbusy, D2);
    check("alt_sweep_done", ndone, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
